// File: rtl/pipe_perf_monitor_if.sv
// rtl/pipe_perf_monitor_if.sv - control, event and readback bundle for pipe_perf_monitor
interface pipe_perf_monitor_if #(
  parameter int NUM_EVT = 4,
  parameter int CNT_W   = 32,
  parameter int SEL_W   = 4
);
  logic               start_i;
  logic               clear_i;
  logic [NUM_EVT-1:0] evt_i;
  logic [SEL_W-1:0]   rd_sel_i;
  logic [CNT_W-1:0]   rd_data_o;
  logic [CNT_W-1:0]   cycle_o;
  logic [1:0]         state_o;
  logic               done_o;
  logic [NUM_EVT-1:0] ovf_o;

  modport master (
    output start_i, clear_i, evt_i, rd_sel_i,
    input  rd_data_o, cycle_o, state_o, done_o, ovf_o
  );

  modport slave (
    input  start_i, clear_i, evt_i, rd_sel_i,
    output rd_data_o, cycle_o, state_o, done_o, ovf_o
  );
endinterface

// File: rtl/pipe_perf_monitor.sv
// rtl/pipe_perf_monitor.sv - windowed per-event pipeline performance counters
// PERF_SATURATE_EN: counters saturate at all-ones instead of wrapping.
module pipe_perf_monitor #(
  parameter int NUM_EVT   = 4,
  parameter int CNT_W     = 32,
  parameter int MAX_CYCLE = 30,
  parameter int SEL_W     = 4
) (
  input  logic                clk_i,
  input  logic                rst_n_i,
  pipe_perf_monitor_if.slave  bus
);
  typedef enum logic [1:0] {
    S_IDLE = 2'b00,
    S_RUN  = 2'b01,
    S_DONE = 2'b10
  } state_t;

  localparam logic [CNT_W-1:0] CNT_MAX = '1;
  localparam logic [CNT_W-1:0] LIMIT   = CNT_W'(MAX_CYCLE);

  state_t             state_q, state_d;
  logic [CNT_W-1:0]   cnt_q [NUM_EVT];
  logic [CNT_W-1:0]   cycle_q, cycle_inc, rd_mux, rd_q;
  logic [NUM_EVT-1:0] ovf_q;
  logic               count_en;
  logic               done;

`ifdef PERF_SATURATE_EN
  assign cycle_inc = (cycle_q == CNT_MAX) ? cycle_q : cycle_q + CNT_W'(1);
`else
  assign cycle_inc = cycle_q + CNT_W'(1);
`endif

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) state_q <= S_IDLE;
    else          state_q <= state_d;
  end

  // Auto-stop compares the post-increment cycle so the final edge still counts.
  always_comb begin
    state_d = state_q;
    if (bus.clear_i) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: if (bus.start_i) state_d = S_RUN;
        S_RUN: begin
          if (!bus.start_i)
            state_d = S_IDLE;
          else if (MAX_CYCLE != 0 && cycle_inc == LIMIT)
            state_d = S_DONE;
        end
        S_DONE:  state_d = S_DONE;
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    count_en = (state_q == S_RUN) && bus.start_i;
    done     = (state_q == S_DONE);
  end

  always_comb begin
    rd_mux = '0;
    for (int k = 0; k < NUM_EVT; k++)
      if (bus.rd_sel_i == SEL_W'(k)) rd_mux = cnt_q[k];
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      cycle_q <= '0;
      rd_q    <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
    end else if (bus.clear_i) begin
      cycle_q <= '0;
      rd_q    <= '0;
      ovf_q   <= '0;
      for (int k = 0; k < NUM_EVT; k++) cnt_q[k] <= '0;
    end else begin
      rd_q <= rd_mux;
      if (count_en) begin
        cycle_q <= cycle_inc;
        for (int k = 0; k < NUM_EVT; k++) begin
          if (bus.evt_i[k]) begin
            if (cnt_q[k] == CNT_MAX) ovf_q[k] <= 1'b1;
`ifdef PERF_SATURATE_EN
            if (cnt_q[k] != CNT_MAX) cnt_q[k] <= cnt_q[k] + CNT_W'(1);
`else
            cnt_q[k] <= cnt_q[k] + CNT_W'(1);
`endif
          end
        end
      end
    end
  end

  assign bus.rd_data_o = rd_q;
  assign bus.cycle_o   = cycle_q;
  assign bus.state_o   = state_q;
  assign bus.done_o    = done;
  assign bus.ovf_o     = ovf_q;
endmodule

// File: tb/tb_pipe_perf_monitor.sv
// tb/tb_pipe_perf_monitor.sv - self-checking bench for pipe_perf_monitor
module tb_pipe_perf_monitor;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  pipe_perf_monitor_if #(.NUM_EVT(4), .CNT_W(32), .SEL_W(4)) ifa ();
  pipe_perf_monitor_if #(.NUM_EVT(4), .CNT_W(4),  .SEL_W(4)) ifb ();

  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(32), .MAX_CYCLE(30), .SEL_W(4)) dut_a (
    .clk_i(clk), .rst_n_i(rst_n), .bus(ifa)
  );
  pipe_perf_monitor #(.NUM_EVT(4), .CNT_W(4), .MAX_CYCLE(0), .SEL_W(4)) dut_b (
    .clk_i(clk), .rst_n_i(rst_n), .bus(ifb)
  );

  int vectors = 0;
  int miscompares = 0;
  bit use_model = 1'b0;

  // Reference: index 0 models dut_a, index 1 models dut_b.
  longint unsigned m_cnt [2][4];
  longint unsigned m_cyc [2];
  longint unsigned m_rd  [2];
  logic [3:0]      m_ovf [2];
  int              m_st  [2];   // 0 idle, 1 running, 2 finished
  int              m_w   [2] = '{32, 4};
  int              m_max [2] = '{30, 0};

  typedef struct {
    bit         start;
    bit         clear;
    logic [3:0] evt;
    logic [3:0] sel;
    int         cyc;
    int         st;
    int         rd;
  } vec_t;
  vec_t tbl [13];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic model_reset();
    for (int d = 0; d < 2; d++) begin
      m_cyc[d] = 0; m_rd[d] = 0; m_ovf[d] = '0; m_st[d] = 0;
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
    end
  endtask

  task automatic model_edge(input int d, input bit start, input bit clear,
                            input logic [3:0] evt, input int sel);
    longint unsigned top;
    top = (64'd1 << m_w[d]) - 64'd1;
    if (clear) begin
      m_cyc[d] = 0; m_rd[d] = 0; m_ovf[d] = '0; m_st[d] = 0;
      for (int k = 0; k < 4; k++) m_cnt[d][k] = 0;
      return;
    end
    m_rd[d] = (sel < 4) ? m_cnt[d][sel] : 0;
    if (m_st[d] == 1 && start) begin
`ifdef PERF_SATURATE_EN
      if (m_cyc[d] != top) m_cyc[d] = m_cyc[d] + 1;
`else
      m_cyc[d] = (m_cyc[d] + 1) % (top + 1);
`endif
      for (int k = 0; k < 4; k++) begin
        if (evt[k]) begin
          if (m_cnt[d][k] == top) begin
            m_ovf[d][k] = 1'b1;
`ifndef PERF_SATURATE_EN
            m_cnt[d][k] = 0;
`endif
          end else begin
            m_cnt[d][k] = m_cnt[d][k] + 1;
          end
        end
      end
      if (m_max[d] != 0 && m_cyc[d] == longint'(m_max[d])) m_st[d] = 2;
    end else if (m_st[d] == 1) begin
      m_st[d] = 0;
    end else if (m_st[d] == 0 && start) begin
      m_st[d] = 1;
    end
  endtask

  task automatic check_dut(input int d);
    if (d == 0) begin
      chk("a_cycle", ifa.cycle_o,   m_cyc[0]);
      chk("a_state", ifa.state_o,   m_st[0]);
      chk("a_done",  ifa.done_o,    m_st[0] == 2);
      chk("a_ovf",   ifa.ovf_o,     m_ovf[0]);
      chk("a_rd",    ifa.rd_data_o, m_rd[0]);
    end else begin
      chk("b_cycle", ifb.cycle_o,   m_cyc[1]);
      chk("b_state", ifb.state_o,   m_st[1]);
      chk("b_done",  ifb.done_o,    m_st[1] == 2);
      chk("b_ovf",   ifb.ovf_o,     m_ovf[1]);
      chk("b_rd",    ifb.rd_data_o, m_rd[1]);
    end
  endtask

  task automatic step(input bit start, input bit clear, input logic [3:0] evt,
                      input logic [3:0] sel);
    ifa.start_i = start; ifa.clear_i = clear; ifa.evt_i = evt; ifa.rd_sel_i = sel;
    ifb.start_i = start; ifb.clear_i = clear; ifb.evt_i = evt; ifb.rd_sel_i = sel;
    @(posedge clk);
    model_edge(0, start, clear, evt, int'(sel));
    model_edge(1, start, clear, evt, int'(sel));
    #1;
    if (use_model) begin
      check_dut(0);
      check_dut(1);
    end
  endtask

  initial begin
    tbl[0] = '{1'b1, 1'b0, 4'h0, 4'd0, 0, 1, 0};
    for (int i = 1; i <= 7; i++) tbl[i] = '{1'b1, 1'b0, 4'hF, 4'd3, i, 1, i - 1};
    tbl[8]  = '{1'b1, 1'b0, 4'h0, 4'd3, 8, 1, 7};
    tbl[9]  = '{1'b1, 1'b0, 4'h0, 4'd9, 9, 1, 0};
    tbl[10] = '{1'b0, 1'b0, 4'h0, 4'd0, 9, 0, 7};
    tbl[11] = '{1'b0, 1'b0, 4'hF, 4'd2, 9, 0, 7};
    tbl[12] = '{1'b0, 1'b1, 4'h0, 4'd0, 0, 0, 0};

    ifa.start_i = 0; ifa.clear_i = 0; ifa.evt_i = '0; ifa.rd_sel_i = '0;
    ifb.start_i = 0; ifb.clear_i = 0; ifb.evt_i = '0; ifb.rd_sel_i = '0;
    model_reset();
    #2;
    chk("rst_cycle", ifa.cycle_o, 0);
    chk("rst_state", ifa.state_o, 0);
    chk("rst_done",  ifa.done_o, 0);
    chk("rst_ovf",   ifa.ovf_o, 0);
    chk("rst_rd",    ifa.rd_data_o, 0);
    #10 rst_n = 1'b1;

    // Simultaneous events and read port, from the table.
    use_model = 1'b0;
    for (int i = 0; i < 13; i++) begin
      step(tbl[i].start, tbl[i].clear, tbl[i].evt, tbl[i].sel);
      chk($sformatf("tbl%0d_cycle", i), ifa.cycle_o,   tbl[i].cyc);
      chk($sformatf("tbl%0d_state", i), ifa.state_o,   tbl[i].st);
      chk($sformatf("tbl%0d_rd", i),    ifa.rd_data_o, tbl[i].rd);
      chk($sformatf("tbl%0d_done", i),  ifa.done_o,    0);
    end
    use_model = 1'b1;

    // Basic window: evt0 every 3rd run cycle, auto-stop at 30.
    step(1, 0, 4'h0, 4'd0);
    for (int i = 1; i <= 33; i++) step(1, 0, {3'b0, (i % 3) == 0}, 4'd0);
    chk("win_cnt0", ifa.rd_data_o, 10);
    step(1, 0, 4'h1, 4'd1);
    step(1, 0, 4'h1, 4'd1);
    chk("win_cnt1",  ifa.rd_data_o, 0);
    chk("win_cycle", ifa.cycle_o, 30);
    chk("win_done",  ifa.done_o, 1);
    chk("win_state", ifa.state_o, 2);
    step(1, 1, 4'hF, 4'd0);
    chk("done_clr_state", ifa.state_o, 0);
    chk("done_clr_done",  ifa.done_o, 0);

    // Pause and resume on channel 2.
    step(1, 0, 4'h4, 4'd2);
    for (int i = 0; i < 10; i++) step(1, 0, 4'h4, 4'd2);
    for (int i = 0; i < 5; i++) begin
      step(0, 0, 4'h4, 4'd2);
      chk("pause_cycle", ifa.cycle_o, 10);
    end
    chk("pause_cnt2", ifa.rd_data_o, 10);
    step(1, 0, 4'h4, 4'd2);
    for (int i = 0; i < 22; i++) step(1, 0, 4'h4, 4'd2);
    chk("resume_cycle", ifa.cycle_o, 30);
    chk("resume_cnt2",  ifa.rd_data_o, 30);
    chk("resume_done",  ifa.done_o, 1);

    // Clear wins over a full event vector in RUN.
    step(0, 1, 4'h0, 4'd0);
    step(1, 0, 4'hF, 4'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 4'hF, 4'd0);
    step(1, 1, 4'hF, 4'd0);
    chk("clr_cycle", ifa.cycle_o, 0);
    chk("clr_ovf",   ifa.ovf_o, 0);
    chk("clr_state", ifa.state_o, 0);
    chk("clr_rd",    ifa.rd_data_o, 0);

    // Asynchronous reset between edges.
    step(1, 0, 4'h1, 4'd0);
    for (int i = 0; i < 12; i++) step(1, 0, 4'h1, 4'd0);
    chk("arst_pre_cycle", ifa.cycle_o, 12);
    #3 rst_n = 1'b0;
    #1;
    chk("arst_cycle", ifa.cycle_o, 0);
    chk("arst_state", ifa.state_o, 0);
    chk("arst_rd",    ifa.rd_data_o, 0);
    chk("arst_ovf",   ifa.ovf_o, 0);
    chk("arst_done",  ifa.done_o, 0);
    model_reset();
    #2 rst_n = 1'b1;
    step(1, 0, 4'h0, 4'd0);
    for (int i = 0; i < 3; i++) step(1, 0, 4'h1, 4'd0);
    chk("arst_restart_cycle", ifa.cycle_o, 3);
    chk("arst_restart_state", ifa.state_o, 1);

    // 4-bit counter overflow on dut_b.
    step(0, 1, 4'h0, 4'd0);
    step(1, 0, 4'h0, 4'd0);
    for (int i = 0; i < 15; i++) step(1, 0, 4'h1, 4'd0);
    chk("ovf_before", ifb.ovf_o[0], 0);
    step(1, 0, 4'h1, 4'd0);
    step(1, 0, 4'h1, 4'd0);
    step(1, 0, 4'h0, 4'd0);
`ifdef PERF_SATURATE_EN
    chk("ovf_cnt0", ifb.rd_data_o, 15);
`else
    chk("ovf_cnt0", ifb.rd_data_o, 1);
`endif
    chk("ovf_flag", ifb.ovf_o[0], 1);

    // Randomised traffic against the reference.
    step(0, 1, 4'h0, 4'd0);
    for (int i = 0; i < 400; i++)
      step($urandom_range(0, 9) != 0, $urandom_range(0, 49) == 0,
           4'($urandom), 4'($urandom_range(0, 15)));

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
